// File: rtl/bandpower_pkg.sv
// Shared widths and helpers for the band-power scheduler.
// Holds the accumulator width rule and the saturating mean-power scaler.
package bandpower_pkg;

    localparam int SAMPLE_W = 16;
    localparam int POWER_W  = 16;
    localparam int SQ_W     = 2*SAMPLE_W - 1;
    localparam int WIDE_W   = 64;

    // 2^win_log2 squares of at most 2^30 each can never overflow this width.
    function automatic int acc_width(input int win_log2);
        return SQ_W + win_log2;
    endfunction

    function automatic logic [POWER_W-1:0] scale_power(input logic [WIDE_W-1:0] total,
                                                       input int shift);
        logic [WIDE_W-1:0] s;
        s = total >> shift;
        if (|s[WIDE_W-1:POWER_W]) begin
            return '1;
        end
        return s[POWER_W-1:0];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter; priority starts just after the last granted request.
// Combinational grant, no latency; en=0 forces no grant and freezes the pointer.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] last_q, last_d;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        gnt    = '0;
        last_d = last_q;
        found  = 1'b0;
        idx    = '0;
        if (en) begin
            for (int i = 1; i <= N; i++) begin
                idx = PTR_W'((int'(last_q) + i) % N);
                if (!found && req[idx]) begin
                    found    = 1'b1;
                    gnt[idx] = 1'b1;
                    last_d   = idx;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= PTR_W'(N - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/bandpower_sched.sv
// Shares one square-and-accumulate path among N_CH streams, one mean-power word per window.
// Result 1 cycle after the window-final sample; a held output freezes grants and both stages.
module bandpower_sched
    import bandpower_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int WIN_LOG2  = 6,
    parameter int OUT_SHIFT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic [N_CH-1:0]          in_valid,
    input  logic [SAMPLE_W*N_CH-1:0] in_data,
    output logic [N_CH-1:0]          in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(N_CH)-1:0]  out_ch,
    output logic [POWER_W-1:0]       out_power,
    output logic                     busy
);
    localparam int CH_W  = $clog2(N_CH);
    localparam int ACC_W = acc_width(WIN_LOG2);
    localparam logic [WIN_LOG2-1:0] CNT_MAX = '1;

    logic [ACC_W-1:0]    acc_q [N_CH];
    logic [ACC_W-1:0]    acc_d [N_CH];
    logic [WIN_LOG2-1:0] cnt_q [N_CH];
    logic [WIN_LOG2-1:0] cnt_d [N_CH];

    logic               s1_vld_q, s1_vld_d;
    logic [CH_W-1:0]    s1_ch_q, s1_ch_d;
    logic [SQ_W-1:0]    s1_sq_q, s1_sq_d;
    logic               out_valid_q, out_valid_d;
    logic [CH_W-1:0]    out_ch_q, out_ch_d;
    logic [POWER_W-1:0] out_power_q, out_power_d;

    logic                stall;
    logic                arb_en;
    logic [N_CH-1:0]     gnt;
    logic [SAMPLE_W-1:0] sel_smp;
    logic [SAMPLE_W-1:0] sel_mag;
    logic [CH_W-1:0]     sel_ch;
    logic [SQ_W-1:0]     sel_sq;
    logic [ACC_W-1:0]    total;

    assign stall  = out_valid_q & ~out_ready;
    assign arb_en = ~stall & ~clear & ~rst;

    rr_arbiter #(.N(N_CH)) u_arb (
        .clk (clk),
        .rst (rst),
        .en  (arb_en),
        .req (in_valid),
        .gnt (gnt)
    );

    // Squaring the magnitude keeps the product unsigned; 0x8000 maps to 32768 exactly.
    always_comb begin
        sel_smp = '0;
        sel_ch  = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (gnt[k]) begin
                sel_smp = in_data[SAMPLE_W*k +: SAMPLE_W];
                sel_ch  = CH_W'(k);
            end
        end
        sel_mag = sel_smp[SAMPLE_W-1] ? (~sel_smp + 1'b1) : sel_smp;
        sel_sq  = SQ_W'(sel_mag) * SQ_W'(sel_mag);
    end

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        s1_vld_d    = s1_vld_q;
        s1_ch_d     = s1_ch_q;
        s1_sq_d     = s1_sq_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_power_d = out_power_q;
        total       = acc_q[s1_ch_q] + ACC_W'(s1_sq_q);
        if (clear) begin
            for (int k = 0; k < N_CH; k++) begin
                acc_d[k] = '0;
                cnt_d[k] = '0;
            end
            s1_vld_d    = 1'b0;
            out_valid_d = 1'b0;
        end else if (!stall) begin
            s1_vld_d = |gnt;
            s1_ch_d  = sel_ch;
            s1_sq_d  = sel_sq;
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            if (s1_vld_q) begin
                if (cnt_q[s1_ch_q] == CNT_MAX) begin
                    acc_d[s1_ch_q] = '0;
                    cnt_d[s1_ch_q] = '0;
                    out_valid_d    = 1'b1;
                    out_ch_d       = s1_ch_q;
                    out_power_d    = scale_power(WIDE_W'(total), WIN_LOG2 + OUT_SHIFT);
                end else begin
                    acc_d[s1_ch_q] = total;
                    cnt_d[s1_ch_q] = cnt_q[s1_ch_q] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) begin
                acc_q[k] <= '0;
                cnt_q[k] <= '0;
            end
            s1_vld_q    <= 1'b0;
            s1_ch_q     <= '0;
            s1_sq_q     <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_power_q <= '0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            s1_vld_q    <= s1_vld_d;
            s1_ch_q     <= s1_ch_d;
            s1_sq_q     <= s1_sq_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_power_q <= out_power_d;
        end
    end

    always_comb begin
        busy = s1_vld_q | out_valid_q;
        for (int k = 0; k < N_CH; k++) begin
            if (cnt_q[k] != '0) begin
                busy = 1'b1;
            end
        end
    end

    assign in_ready  = gnt;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_power = out_power_q;

endmodule

// File: doc/bandpower_sched.md
# bandpower_sched

Multi-channel band-power scheduler that shares one square-and-accumulate datapath among `N_CH` ECG sample streams. It grants channels round-robin, keeps a per-channel accumulator and window counter, and emits one scaled mean-power word per completed window on a valid/ready output tagged with the channel index. It sits between the per-lead filter outputs and the feature/classifier stage, replacing one power unit per lead.

## Interface
- `N_CH`, 4: number of input channels (2..16)
- `WIN_LOG2`, 6: window length = 2^WIN_LOG2 samples per channel
- `OUT_SHIFT`, 8: extra right shift applied to the mean power before saturation
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high
- `clear`  in  1  synchronous flush of all accumulators, counters, pipeline and output
- `in_valid`  in  N_CH  per-channel sample valid
- `in_data`  in  16*N_CH  signed samples, channel k at [16k+15:16k]
- `in_ready`  out  N_CH  one-hot grant; at most one bit high
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer accepts result
- `out_ch`  out  clog2(N_CH)  channel of result
- `out_power`  out  16  unsigned saturated power
- `busy`  out  1  any sample in flight or any counter non-zero

## Operation
- `stall` = out_valid & ~out_ready. Whole pipeline advances only when `stall`=0.
- Arbiter: when ~stall & ~clear, `in_ready[k]` = 1 for the first k with `in_valid[k]` searching from `last+1` cyclically; `last` updates to k only on a grant. Reset `last` = N_CH-1 (channel 0 highest first). `in_ready` is combinational from `in_valid`, `last`, `stall`, `clear`.
- Stage 1 (accept edge): register `sq = in_data[k]*in_data[k]` (unsigned 31 bits), channel k, valid bit.
- Stage 2 (next advancing edge): `acc[k] += sq`, `cnt[k] += 1`. When `cnt[k]` was 2^WIN_LOG2-1: load output register with `min(total >> (WIN_LOG2+OUT_SHIFT), 16'hFFFF)` where total includes this sample, set `out_ch`=k, `out_valid`=1; zero `acc[k]`, `cnt[k]`.
- Accumulator width ACC_W = 31+WIN_LOG2; no wrap possible.
- Read-modify-write of `acc`/`cnt` happens only in stage 2, so back-to-back grants of the same channel need no forwarding.
- `out_valid` drops on the edge where out_valid & out_ready unless a new result loads on the same edge (then stays 1 with new data).
- `clear` (sync): zero all `acc`, `cnt`, stage-1 valid, `out_valid`; `last` unchanged; has priority over every other update in that cycle.
- Reset values: `out_valid`=0, `out_ch`=0, `out_power`=0, `busy`=0, `in_ready`=0 while `rst`, all accumulators/counters 0.

## Timing
- Sample accepted at edge E0 → contributes to `acc` at E1 → if window-final, `out_valid`=1 after E1 (1-cycle latency, assuming no stall).
- Throughput: one sample per cycle aggregate across all channels.
- During stall: `in_ready`=0, stage 1 and stage 2 hold, no counter changes.
- `rst` asserted mid-window: all state cleared immediately, partial windows discarded.
- Two channels finishing on consecutive cycles with `out_ready`=1 produce consecutive out_valid cycles.

## Structure
- Shared package `bandpower_pkg`: `SAMPLE_W`=16, `POWER_W`=16, `acc_width(win_log2)` function, saturating power-scale function.
- One sub-module: `rr_arbiter` (N requests, one-hot grant, `last` pointer, advance enable).
- Per-channel `acc`/`cnt` as register arrays in the top level.

## Test plan
- Single channel 0, 64 samples of +256, out_ready=1 → one result after 64th sample + 1 cycle: out_ch=0, out_power=256 (65536>>14... = 4·2^20>>14=256).
- All 4 channels valid every cycle, constant +1024 → grants 0,1,2,3 repeating; four results ch0..ch3 on consecutive cycles, each out_power=4096.
- Samples −32768 for 64 cycles, OUT_SHIFT=0 → out_power=16'hFFFF (saturation).
- Hold out_ready=0 while result pending → in_ready all 0, counters frozen; release → result drains, grants resume, totals unchanged.
- Assert `clear` after 30 samples on ch1 → out_valid=0, busy=0; next result for ch1 requires a full 64 new samples.
- Async `rst` pulse mid-window between edges → outputs go to reset values immediately; no spurious out_valid afterward.
